// File: rtl/spi_master.sv
// SPI master with a small byte-wide register interface.
// One 8-bit transfer per DATA write; CPOL/CPHA/LSBF selectable; sticky DONE with IRQ.
module spi_master #(
  parameter int         NUM_SS    = 4,
  parameter logic [7:0] RESET_DIV = 8'h00
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [2:0]        AD,
  input  logic [7:0]        DI,
  output logic [7:0]        DO,
  input  logic              rw,
  input  logic              cs,
  output logic              irq,
  output logic              sck,
  output logic              mosi,
  input  logic              miso,
  output logic [NUM_SS-1:0] ss_n
);

  typedef enum logic {IDLE, SHIFT} state_t;

  state_t              state, state_nxt;
  logic [7:0]          presc, mode, tx_buf, rx_sr, rx_nxt, rx_data, rd_mux;
  logic [NUM_SS-1:0]   ss;
  logic                done;
  logic [7:0]          div_cnt;
  logic [3:0]          hcnt, hcnt_m1;
  logic [2:0]          tx_idx, rx_idx;

  logic cpol, cpha, lsbf, ie;
  logic rdy, rd, wr, start, half_end, last_half, sample;

  assign cpol = mode[0];
  assign cpha = mode[1];
  assign lsbf = mode[2];
  assign ie   = mode[7];

  assign rdy       = (state == IDLE);
  assign rd        = cs & rw;
  assign wr        = cs & ~rw;
  assign start     = wr && (AD == 3'd1) && rdy;
  assign half_end  = (state == SHIFT) && (div_cnt == presc);
  assign last_half = half_end && (hcnt == 4'd15);
  // CPHA=0 samples at the end of even half-periods (leading), CPHA=1 at odd (trailing)
  assign sample    = half_end && (hcnt[0] == cpha);

  // Bit k of the transfer occupies half-periods 2k,2k+1 (CPHA=0) or 2k+1,2k+2 (CPHA=1);
  // with CPHA=1 bit 0 is also presented during half 0 so mosi is never undefined.
  assign hcnt_m1 = hcnt - 4'd1;
  assign tx_idx  = (cpha && hcnt != 4'd0) ? hcnt_m1[3:1] : hcnt[3:1];
  assign rx_idx  = hcnt[3:1];

  assign sck  = (state == SHIFT) ? (cpol ^ hcnt[0]) : cpol;
  assign mosi = (state == SHIFT) ? tx_buf[lsbf ? tx_idx : ~tx_idx] : 1'b1;
  assign ss_n = ~ss;
  assign irq  = ie & done;

  // Merge the bit being sampled this cycle so completion can capture all 8 bits
  always_comb begin
    rx_nxt = rx_sr;
    if (sample) rx_nxt[lsbf ? rx_idx : ~rx_idx] = miso;
  end

  // Read-data mux
  always_comb begin
    rd_mux = 8'h00;
    case (AD)
      3'd0: rd_mux = {rdy, done, 6'b0};
      3'd1: rd_mux = rx_data;
      3'd2: rd_mux = presc;
      3'd3: rd_mux = 8'(ss);
      3'd4: rd_mux = mode;
      default: rd_mux = 8'h00;
    endcase
  end

  // Next-state logic
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (start) state_nxt = SHIFT;
      SHIFT:   if (last_half) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // State register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  // Half-period timing and shift data
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      div_cnt <= 8'h00;
      hcnt    <= 4'd0;
      tx_buf  <= 8'h00;
      rx_sr   <= 8'h00;
      rx_data <= 8'hFF;
    end else begin
      if (start) begin
        div_cnt <= 8'h00;
        hcnt    <= 4'd0;
        tx_buf  <= DI;
      end else if (half_end) begin
        div_cnt <= 8'h00;
        hcnt    <= hcnt + 4'd1;
      end else if (state == SHIFT) begin
        div_cnt <= div_cnt + 8'd1;
      end
      rx_sr <= rx_nxt;
      if (last_half) rx_data <= rx_nxt;
    end
  end

  // Configuration registers; PRESCALER/MODE locked while a transfer runs
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      presc <= RESET_DIV;
      mode  <= 8'h00;
      ss    <= '0;
    end else if (wr) begin
      if (AD == 3'd2 && rdy) presc <= DI;
      if (AD == 3'd4 && rdy) mode  <= DI & 8'h87;
      if (AD == 3'd3)        ss    <= DI[NUM_SS-1:0];
    end
  end

  // Sticky DONE: completion wins over a same-cycle clear
  always_ff @(posedge clk or posedge rst) begin
    if (rst)                                 done <= 1'b0;
    else if (last_half)                      done <= 1'b1;
    else if ((rd && AD == 3'd1) || start)    done <= 1'b0;
  end

  // Registered read port
  always_ff @(posedge clk or posedge rst) begin
    if (rst)     DO <= 8'h00;
    else if (rd) DO <= rd_mux;
  end

endmodule

// File: tb/tb_spi_master.sv
// Randomized bench for spi_master with a behavioural SPI slave and transfer model.
module tb_spi_master;

  logic       clk = 1'b0, rst = 1'b1;
  logic [2:0] AD = 3'd0;
  logic [7:0] DI = 8'h00;
  logic [7:0] DO;
  logic       rw = 1'b0, cs = 1'b0, miso = 1'b1;
  logic       irq, sck, mosi;
  logic [3:0] ss_n;

  int n_vec = 0, n_bad = 0;
  logic [7:0] last_rx = 8'hFF;

  spi_master #(.NUM_SS(4), .RESET_DIV(8'h00)) dut (
    .clk(clk), .rst(rst), .AD(AD), .DI(DI), .DO(DO), .rw(rw), .cs(cs),
    .irq(irq), .sck(sck), .mosi(mosi), .miso(miso), .ss_n(ss_n)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  function automatic logic [7:0] rev8(input logic [7:0] b);
    logic [7:0] r;
    for (int i = 0; i < 8; i++) r[i] = b[7-i];
    return r;
  endfunction

  task automatic tick();
    @(posedge clk); #1;
  endtask

  task automatic wr_reg(input logic [2:0] a, input logic [7:0] d);
    cs = 1'b1; rw = 1'b0; AD = a; DI = d;
    tick();
    cs = 1'b0;
  endtask

  task automatic rd_reg(input logic [2:0] a, output logic [7:0] v);
    cs = 1'b1; rw = 1'b1; AD = a;
    tick();
    cs = 1'b0;
    v = DO;
  endtask

  // One transfer: slave returns sb in the configured bit order; optional bus
  // interference mid-transfer and a DATA read on the completion cycle.
  task automatic xfer(input logic [7:0] md, input logic [7:0] ps, input logic [7:0] tx,
                      input logic [7:0] sb, input bit interfere, input bit rd_at_done);
    logic [7:0] v, s_ord, exp_seq, got;
    logic [3:0] ssv, ssn_exp;
    logic cpol, cpha, lsbf, ie, prev_sck, prev_mosi;
    int n_exp, busy, tg, halfbad, lead, trail, last_tgl, kind;

    ssv = 4'($urandom_range(1, 15));
    ssn_exp = ~ssv;
    wr_reg(3'd4, md);
    wr_reg(3'd2, ps);
    wr_reg(3'd3, {4'h0, ssv});
    chk("ss_n", ss_n, ssn_exp);
    rd_reg(3'd4, v);
    chk("mode_rb", v, md & 8'h87);

    cpol = md[0]; cpha = md[1]; lsbf = md[2]; ie = md[7];
    n_exp   = 16 * (int'(ps) + 1);
    s_ord   = lsbf ? rev8(sb) : sb;
    exp_seq = lsbf ? rev8(tx) : tx;
    miso    = s_ord[7];
    chk("idle_sck", sck, cpol);
    chk("idle_mosi", mosi, 1);

    cs = 1'b1; rw = 1'b0; AD = 3'd1; DI = tx;
    tick();
    prev_sck = sck; prev_mosi = mosi;
    got = 8'h00; busy = -1; tg = 0; halfbad = 0; lead = 0; trail = 0; last_tgl = 0;

    for (int c = 1; c <= 4000 && busy < 0; c++) begin
      cs = 1'b1; kind = 0; rw = 1'b1; AD = 3'd0;
      if (interfere && c == 3)       begin rw = 1'b0; AD = 3'd1; DI = ~tx; kind = 1; end
      else if (interfere && c == 4)  begin rw = 1'b0; AD = 3'd2; DI = ps + 8'd5; kind = 1; end
      else if (rd_at_done && c == n_exp) begin AD = 3'd1; kind = 2; end
      tick();
      if (c == 2) chk("irq_busy", irq, 0);
      if (sck !== prev_sck) begin
        tg++;
        if (c - last_tgl != int'(ps) + 1) halfbad++;
        last_tgl = c;
        if (prev_sck == cpol) begin
          if (!cpha) got = {got[6:0], prev_mosi};
          else if (lead < 8) miso = s_ord[7-lead];
          lead++;
        end else begin
          if (cpha) got = {got[6:0], prev_mosi};
          else if (trail < 7) miso = s_ord[6-trail];
          trail++;
        end
      end
      prev_sck = sck; prev_mosi = mosi;
      if (kind == 2) chk("data_at_done", DO, last_rx);
      if (kind == 0 && DO[7]) busy = c - 1;
    end
    cs = 1'b0;

    if (busy < 0) chk("timeout", 0, 1);
    chk("busy_cycles", busy, n_exp);
    chk("sck_toggles", tg, 16);
    chk("half_len", halfbad, 0);
    chk("mosi_seq", got, exp_seq);
    chk("sck_end", sck, cpol);
    chk("irq_done", irq, ie);
    rd_reg(3'd0, v);
    chk("status_done", v, 8'hC0);
    rd_reg(3'd1, v);
    chk("rx_data", v, sb);
    last_rx = sb;
    chk("irq_clr", irq, 0);
    rd_reg(3'd0, v);
    chk("status_clr", v, 8'h80);
    if (interfere) begin
      rd_reg(3'd2, v);
      chk("presc_locked", v, ps);
    end
  endtask

  // Reset asserted during the 5th half-period aborts the transfer
  task automatic reset_mid(input logic [7:0] md, input logic [7:0] ps);
    logic [7:0] v;
    logic prev_sck;
    int tg;
    wr_reg(3'd4, md);
    wr_reg(3'd2, ps);
    wr_reg(3'd3, 8'h0F);
    wr_reg(3'd1, 8'h5A);
    prev_sck = sck; tg = 0;
    for (int c = 0; c < 2000 && tg < 4; c++) begin
      tick();
      if (sck !== prev_sck) tg++;
      prev_sck = sck;
    end
    chk("rst_wait", tg, 4);
    #2 rst = 1'b1;
    #1;
    chk("rst_sck", sck, 0);
    chk("rst_mosi", mosi, 1);
    chk("rst_ss_n", ss_n, 4'hF);
    chk("rst_irq", irq, 0);
    chk("rst_do", DO, 8'h00);
    @(negedge clk) rst = 1'b0;
    tick();
    rd_reg(3'd0, v);
    chk("rst_status", v, 8'h80);
    rd_reg(3'd1, v);
    chk("rst_data", v, 8'hFF);
    last_rx = 8'hFF;
  endtask

  initial begin
    logic [7:0] v, md;
    logic [7:0] exp_rd [8];
    exp_rd = '{8'h80, 8'hFF, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00};

    #2;
    chk("reset_sck", sck, 0);
    chk("reset_mosi", mosi, 1);
    chk("reset_ss_n", ss_n, 4'hF);
    chk("reset_irq", irq, 0);
    chk("reset_do", DO, 8'h00);
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    tick();
    for (int a = 0; a < 8; a++) begin
      rd_reg(3'(a), v);
      chk($sformatf("reset_reg%0d", a), v, exp_rd[a]);
    end

    xfer(8'h00, 8'd0, 8'hA5, 8'hA5, 1'b0, 1'b0);
    xfer(8'h83, 8'd3, 8'h3C, 8'h00, 1'b0, 1'b0);
    xfer(8'h04, 8'd0, 8'h01, 8'h01, 1'b0, 1'b0);
    xfer(8'h00, 8'd2, 8'($urandom), 8'($urandom), 1'b1, 1'b0);
    xfer(8'h80, 8'd1, 8'($urandom), 8'($urandom), 1'b0, 1'b1);
    for (int i = 0; i < 8; i++) begin
      md = {1'($urandom), 4'h0, 3'($urandom)};
      xfer(md, 8'($urandom_range(0, 4)), 8'($urandom), 8'($urandom),
           1'($urandom), 1'($urandom));
    end
    reset_mid(8'h00, 8'd1);
    xfer(8'h02, 8'd1, 8'($urandom), 8'($urandom), 1'b0, 1'b0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule

// File: doc/spi_master.md
SPI_MASTER -- requirements
Module: spi_master

Interface
REQ-001 Parameter NUM_SS, default 4, meaning number of slave-select outputs (legal range 1..8).
REQ-002 Parameter RESET_DIV, default 8'h00, meaning the reset value of the PRESCALER register.
REQ-003 clk  input  1  sole clock; all state changes on its rising edge.
REQ-004 rst  input  1  reset, asynchronous, active-high.
REQ-005 AD  input  3  register address.
REQ-006 DI  input  8  write data.
REQ-007 DO  output  8  registered read data.
REQ-008 rw  input  1  1 = read, 0 = write.
REQ-009 cs  input  1  register access strobe, one access per clk cycle while high.
REQ-010 irq  output  1  interrupt request, active-high, level.
REQ-011 sck  output  1  SPI clock.
REQ-012 mosi  output  1  SPI data out.
REQ-013 miso  input  1  SPI data in.
REQ-014 ss_n  output  NUM_SS  slave selects, active-low.

Function
REQ-015 Register map SHALL be:
- $0 STATUS (R): bit7 RDY (1 = idle), bit6 DONE (sticky), other bits 0.
- $1 DATA (RW).
- $2 PRESCALER (RW).
- $3 SS (RW), low NUM_SS bits.
- $4 MODE (RW): bit0 CPOL, bit1 CPHA, bit2 LSBF, bit7 IE; other bits read 0.
- $5-$7 read 8'h00; writes ignored.
REQ-016 On a clk edge with cs=1, rw=1, DO SHALL load the addressed register value; DO SHALL otherwise hold.
REQ-017 Writing DATA while RDY=1 SHALL latch DI into the shift register, clear DONE, and set RDY=0 from the next cycle.
REQ-018 Writing DATA while RDY=0 SHALL be ignored.
REQ-019 Writes to PRESCALER or MODE while RDY=0 SHALL be ignored.
REQ-020 SS writes SHALL take effect at any time.
REQ-021 ss_n SHALL equal the bitwise inverse of SS[NUM_SS-1:0].
REQ-022 Each SCK half-period SHALL last exactly PRESCALER+1 clk cycles.
REQ-023 A transfer SHALL consist of 16 half-periods (8 bits), so RDY returns to 1 exactly 16*(PRESCALER+1) cycles after the DATA write edge.
REQ-024 While idle, sck SHALL equal CPOL and mosi SHALL be 1.
REQ-025 If CPHA=0:
- the first data bit SHALL be on mosi from the cycle after the write;
- miso SHALL be sampled on each leading SCK edge;
- mosi SHALL advance on each trailing edge.
REQ-026 If CPHA=1:
- mosi SHALL advance on each leading edge;
- miso SHALL be sampled on each trailing edge.
REQ-027 LSBF=0 SHALL shift MSB first; LSBF=1 SHALL shift LSB first (both directions).
REQ-028 Received data SHALL be assembled in the same bit order as transmitted.
REQ-029 Received data SHALL be readable at DATA once RDY=1; until the next transfer completes, DATA SHALL read the previous value.
REQ-030 On completion, DONE SHALL set.
REQ-031 A DATA read SHALL clear DONE.
REQ-032 If completion and a DONE clear occur in the same cycle, set SHALL win.
REQ-033 irq SHALL equal IE AND DONE, combinationally from registered state.
REQ-034 The internal state machine SHALL have states:
- IDLE -> on accepted DATA write -> SHIFT;
- SHIFT -> after 16th half-period -> IDLE.

Reset
REQ-035 While rst=1, and asynchronously on its assertion, the block SHALL set:
- state IDLE; RDY=1; DONE=0;
- PRESCALER=RESET_DIV; MODE=0; SS=0;
- received data=8'hFF; DO=8'h00.
REQ-036 While rst=1, outputs SHALL be: sck=0, mosi=1, ss_n all 1, irq=0.
REQ-037 Reset asserted mid-transfer SHALL abort it with no completion, leaving DONE=0.

Verification
REQ-038 Mode 0, PRESCALER=0, SS=1, write DATA=8'hA5 with miso looped to mosi -> 16 cycles busy, mosi sequence 1,0,1,0,0,1,0,1, DATA reads 8'hA5, DONE=1.
REQ-039 MODE=8'h83 (CPOL=1, CPHA=1, IE=1), PRESCALER=3, write 8'h3C with miso=0 -> sck idles 1, 64 cycles busy, irq rises at completion, DATA=8'h00, irq falls after DATA read.
REQ-040 MODE=8'h04 (LSBF), write 8'h01, miso driven 1 only on the first sample -> mosi first bit 1 then seven 0s, DATA=8'h01.
REQ-041 Second DATA write and PRESCALER write issued mid-transfer -> both ignored, transfer length and data unchanged.
REQ-042 DATA read on the exact completion cycle -> DONE remains 1.
REQ-043 rst pulsed at the 5th half-period -> sck=CPOL(0), mosi=1, RDY=1, DONE=0, ss_n all 1 immediately, DATA reads 8'hFF.
